// File: rtl/exc_ctrl_unit_pkg.sv
// Shared types and constants for the pipeline exception/stall controller.
// Pause masks stall the named stage together with every earlier stage.
package exc_ctrl_unit_pkg;

  localparam int unsigned PAUSE_W   = 8;
  localparam logic [6:0]  ECODE_INT = 7'h00;

  localparam logic [PAUSE_W-1:0] PAUSE_NONE     = 8'h00;
  localparam logic [PAUSE_W-1:0] PAUSE_IF       = 8'h03;
  localparam logic [PAUSE_W-1:0] PAUSE_ID       = 8'h07;
  localparam logic [PAUSE_W-1:0] PAUSE_DISPATCH = 8'h0F;
  localparam logic [PAUSE_W-1:0] PAUSE_EX       = 8'h1F;
  localparam logic [PAUSE_W-1:0] PAUSE_MEM      = 8'h3F;
  localparam logic [PAUSE_W-1:0] PAUSE_ALL      = 8'h7F;

  typedef enum logic [1:0] {
    StRun,
    StFlush,
    StIdle
  } ctrl_state_t;

  typedef struct packed {
    logic [5:0]      is_exception;
    logic [5:0][6:0] exception_cause;
    logic [31:0]     pc;
    logic [31:0]     exception_addr;
    logic            is_ertn;
    logic            is_idle;
    logic            pause_mem;
  } mem_ctrl_t;

  typedef struct packed {
    logic pause_if;
    logic pause_id;
    logic pause_dispatch;
    logic pause_ex;
    logic pause_mem;
  } pause_t;

  typedef struct packed {
    logic [PAUSE_W-1:0] pause;
    logic               exception_flush;
  } ctrl_t;

  typedef struct packed {
    logic [31:0] exception_new_pc;
    logic        is_interrupt;
  } ctrl_pc_t;

  // The latest requesting stage decides the mask.
  function automatic logic [PAUSE_W-1:0] pause_mask(pause_t req, logic mem_pause);
    if (req.pause_mem || mem_pause) return PAUSE_MEM;
    if (req.pause_ex)               return PAUSE_EX;
    if (req.pause_dispatch)         return PAUSE_DISPATCH;
    if (req.pause_id)               return PAUSE_ID;
    if (req.pause_if)               return PAUSE_IF;
    return PAUSE_NONE;
  endfunction

endpackage

// File: rtl/exc_ctrl_unit_if.sv
// Bundle of MEM report, CSR state and control outputs around exc_ctrl_unit.
// The slave modport is the controller's view; master is the surrounding pipeline.
interface exc_ctrl_unit_if;
  import exc_ctrl_unit_pkg::*;

  mem_ctrl_t   mem_ctrl_i;
  logic        mem_valid_i;
  pause_t      pause_req_i;
  logic        is_interrupt_i;
  logic [31:0] eentry_i;
  logic [31:0] era_i;

  ctrl_t       ctrl_o;
  ctrl_pc_t    ctrl_pc_o;
  logic        csr_exc_valid_o;
  logic [6:0]  csr_exc_cause_o;
  logic [31:0] csr_exc_pc_o;
  logic [31:0] csr_exc_badv_o;
  logic        csr_ertn_o;

  modport master (
    output mem_ctrl_i, mem_valid_i, pause_req_i, is_interrupt_i, eentry_i, era_i,
    input  ctrl_o, ctrl_pc_o, csr_exc_valid_o, csr_exc_cause_o, csr_exc_pc_o,
           csr_exc_badv_o, csr_ertn_o
  );

  modport slave (
    input  mem_ctrl_i, mem_valid_i, pause_req_i, is_interrupt_i, eentry_i, era_i,
    output ctrl_o, ctrl_pc_o, csr_exc_valid_o, csr_exc_cause_o, csr_exc_pc_o,
           csr_exc_badv_o, csr_ertn_o
  );
endinterface

// File: rtl/exc_prio_sel.sv
// Priority select over the per-stage exception flags; the highest index
// (earliest pipeline stage, IF at bit 5) supplies the cause.
module exc_prio_sel (
  input  logic [5:0]      is_exception_i,
  input  logic [5:0][6:0] exception_cause_i,
  output logic            hit_o,
  output logic [6:0]      cause_o
);

  always_comb begin
    hit_o   = |is_exception_i;
    cause_o = '0;
    for (int i = 0; i < 6; i++) begin
      if (is_exception_i[i]) cause_o = exception_cause_i[i];
    end
  end

endmodule

// File: rtl/exc_ctrl_unit.sv
// Pipeline control responder: turns MEM-stage exception/ertn/idle reports into
// stall masks, a one-cycle flush with redirect target, and CSR commit pulses.
module exc_ctrl_unit
  import exc_ctrl_unit_pkg::*;
(
  input logic            clk,
  input logic            rst,
  exc_ctrl_unit_if.slave bus
);

  ctrl_state_t        state_q, state_d;
  logic               flush_q, flush_d;
  logic               exc_valid_q, exc_valid_d;
  logic               ertn_q, ertn_d;
  logic               is_int_q, is_int_d;
  logic [6:0]         cause_q, cause_d;
  logic [31:0]        new_pc_q, new_pc_d;
  logic [31:0]        exc_pc_q, exc_pc_d;
  logic [31:0]        badv_q, badv_d;
  logic [31:0]        idle_pc_q, idle_pc_d;
  logic               exc_hit;
  logic [6:0]         exc_cause;
  logic [PAUSE_W-1:0] pause;

  exc_prio_sel u_prio_sel (
    .is_exception_i    (bus.mem_ctrl_i.is_exception),
    .exception_cause_i (bus.mem_ctrl_i.exception_cause),
    .hit_o             (exc_hit),
    .cause_o           (exc_cause)
  );

  always_comb begin
    state_d     = state_q;
    flush_d     = 1'b0;
    exc_valid_d = 1'b0;
    ertn_d      = 1'b0;
    is_int_d    = is_int_q;
    cause_d     = cause_q;
    new_pc_d    = new_pc_q;
    exc_pc_d    = exc_pc_q;
    badv_d      = badv_q;
    idle_pc_d   = idle_pc_q;
    unique case (state_q)
      StRun: begin
        if (bus.mem_valid_i) begin
          if (bus.is_interrupt_i || exc_hit) begin
            state_d     = StFlush;
            flush_d     = 1'b1;
            exc_valid_d = 1'b1;
            is_int_d    = bus.is_interrupt_i;
            cause_d     = bus.is_interrupt_i ? ECODE_INT : exc_cause;
            new_pc_d    = bus.eentry_i;
            exc_pc_d    = bus.mem_ctrl_i.pc;
            badv_d      = bus.mem_ctrl_i.exception_addr;
          end else if (bus.mem_ctrl_i.is_ertn) begin
            state_d  = StFlush;
            flush_d  = 1'b1;
            ertn_d   = 1'b1;
            is_int_d = 1'b0;
            new_pc_d = bus.era_i;
          end else if (bus.mem_ctrl_i.is_idle) begin
            state_d   = StIdle;
            idle_pc_d = bus.mem_ctrl_i.pc;
          end
        end
      end
      StFlush: state_d = StRun;
      StIdle: begin
        // Wake-up interrupt resumes after the idle instruction.
        if (bus.is_interrupt_i) begin
          state_d     = StFlush;
          flush_d     = 1'b1;
          exc_valid_d = 1'b1;
          is_int_d    = 1'b1;
          cause_d     = ECODE_INT;
          new_pc_d    = bus.eentry_i;
          exc_pc_d    = idle_pc_q + 32'd4;
          badv_d      = bus.mem_ctrl_i.exception_addr;
        end
      end
      default: state_d = StRun;
    endcase
  end

  always_comb begin
    unique case (state_q)
      StRun:   pause = pause_mask(bus.pause_req_i, bus.mem_ctrl_i.pause_mem);
      StIdle:  pause = PAUSE_ALL;
      default: pause = PAUSE_NONE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= StRun;
      flush_q     <= 1'b0;
      exc_valid_q <= 1'b0;
      ertn_q      <= 1'b0;
      is_int_q    <= 1'b0;
      cause_q     <= '0;
      new_pc_q    <= '0;
      exc_pc_q    <= '0;
      badv_q      <= '0;
      idle_pc_q   <= '0;
    end else begin
      state_q     <= state_d;
      flush_q     <= flush_d;
      exc_valid_q <= exc_valid_d;
      ertn_q      <= ertn_d;
      is_int_q    <= is_int_d;
      cause_q     <= cause_d;
      new_pc_q    <= new_pc_d;
      exc_pc_q    <= exc_pc_d;
      badv_q      <= badv_d;
      idle_pc_q   <= idle_pc_d;
    end
  end

  assign bus.ctrl_o          = '{pause: pause, exception_flush: flush_q};
  assign bus.ctrl_pc_o       = '{exception_new_pc: new_pc_q, is_interrupt: is_int_q};
  assign bus.csr_exc_valid_o = exc_valid_q;
  assign bus.csr_exc_cause_o = cause_q;
  assign bus.csr_exc_pc_o    = exc_pc_q;
  assign bus.csr_exc_badv_o  = badv_q;
  assign bus.csr_ertn_o      = ertn_q;

endmodule
